// File: rtl/vec_sweep_checker.sv
// Drives the four 2-bit stimulus vectors into a DUT, holds each for HOLD cycles,
// and compares the DUT's {o1,o2,o3} response against the EXP table.
module vec_sweep_checker #(
  parameter int          HOLD = 5,
  parameter logic [23:0] EXP  = 24'h000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  input  logic [1:0] o1,
  input  logic [1:0] o2,
  input  logic [1:0] o3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] err_mask,
  output logic [1:0] first_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t     r_state;
  logic [1:0] r_vec;
  logic [7:0] r_hold;
  logic       r_in1;
  logic       r_in2;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_errCnt;
  logic [3:0] r_errMask;
  logic [1:0] r_firstErr;

  logic [5:0] w_resp;
  logic [5:0] w_exp;
  logic       w_mismatch;
  logic       w_lastHold;
  logic [2:0] w_cntNext;

  assign w_resp     = {o1, o2, o3};
  assign w_exp      = EXP[6*int'(r_vec) +: 6];
  // Case inequality so that an unknown response bit is treated as a mismatch.
  assign w_mismatch = (w_resp !== w_exp);
  assign w_lastHold = (r_hold == 8'(HOLD - 1));
  assign w_cntNext  = (r_errCnt == 3'd4) ? 3'd4 : r_errCnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vec      <= 2'd0;
      r_hold     <= 8'd0;
      r_in1      <= 1'b0;
      r_in2      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_errCnt   <= 3'd0;
      r_errMask  <= 4'd0;
      r_firstErr <= 2'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= DRIVE;
            r_vec      <= 2'd0;
            r_hold     <= 8'd0;
            r_in1      <= 1'b0;
            r_in2      <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errCnt   <= 3'd0;
            r_errMask  <= 4'd0;
            r_firstErr <= 2'd0;
          end
        end
        DRIVE: begin
          if (!w_lastHold) begin
            r_hold <= r_hold + 8'd1;
          end else begin
            r_hold <= 8'd0;
            if (w_mismatch) begin
              r_errMask[r_vec] <= 1'b1;
              r_errCnt         <= w_cntNext;
              if (r_errCnt == 3'd0) r_firstErr <= r_vec;
            end
            if (r_vec != 2'd3) begin
              r_vec        <= r_vec + 2'd1;
              {r_in1, r_in2} <= r_vec + 2'd1;
            end else begin
              // Pass must account for the vector-3 result sampled on this same edge.
              r_state        <= DONE;
              r_vec          <= 2'd0;
              {r_in1, r_in2} <= 2'b00;
              r_busy         <= 1'b0;
              r_done         <= 1'b1;
              r_pass         <= (r_errCnt == 3'd0) && !w_mismatch;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in1       = r_in1;
  assign in2       = r_in2;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_errCnt;
  assign err_mask  = r_errMask;
  assign first_err = r_firstErr;

endmodule

// File: tb/tb_vec_sweep_checker.sv
// Directed bench for vec_sweep_checker: one HOLD=5 and one HOLD=2 instance, each
// wired to a response table that can be corrupted per vector.
module tb_vec_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       startA, startB;
  logic       in1A, in2A, in1B, in2B;
  logic [1:0] o1A, o2A, o3A, o1B, o2B, o3B;
  logic       busyA, doneA, passA, busyB, doneB, passB;
  logic [2:0] errCntA, errCntB;
  logic [3:0] errMaskA, errMaskB;
  logic [1:0] firstErrA, firstErrB;
  logic [5:0] faultMask [4];

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  vec_sweep_checker #(.HOLD(5), .EXP(24'h1B6CB1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .in1(in1A), .in2(in2A),
    .o1(o1A), .o2(o2A), .o3(o3A), .busy(busyA), .done(doneA), .pass(passA),
    .err_cnt(errCntA), .err_mask(errMaskA), .first_err(firstErrA));

  vec_sweep_checker #(.HOLD(2), .EXP(24'h1B6CB1)) dutB (
    .clk(clk), .rst(rst), .start(startB), .in1(in1B), .in2(in2B),
    .o1(o1B), .o2(o2B), .o3(o3B), .busy(busyB), .done(doneB), .pass(passB),
    .err_cnt(errCntB), .err_mask(errMaskB), .first_err(firstErrB));

  // Good responses for vectors 0..3 are 110001, 110010, 110110, 000110.
  function automatic logic [5:0] goodResp(input logic [1:0] v);
    case (v)
      2'd0:    return 6'b110001;
      2'd1:    return 6'b110010;
      2'd2:    return 6'b110110;
      default: return 6'b000110;
    endcase
  endfunction

  assign {o1A, o2A, o3A} = goodResp({in1A, in2A}) ^ faultMask[{in1A, in2A}];
  assign {o1B, o2B, o3B} = goodResp({in1B, in2B}) ^ faultMask[{in1B, in2B}];

  function automatic logic [3:0] getStatus(input bit sel);
    return sel ? {busyB, doneB, in1B, in2B} : {busyA, doneA, in1A, in2A};
  endfunction

  function automatic logic [9:0] getResult(input bit sel);
    return sel ? {passB, errCntB, errMaskB, firstErrB} : {passA, errCntA, errMaskA, firstErrA};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic val);
    if (sel) startB = val;
    else     startA = val;
  endtask

  task automatic setFaults(input logic [5:0] f0, input logic [5:0] f1, input logic [5:0] f2, input logic [5:0] f3);
    faultMask[0] = f0;
    faultMask[1] = f1;
    faultMask[2] = f2;
    faultMask[3] = f3;
  endtask

  // Starts a sweep at the current point (just after an edge) and follows it to done.
  task automatic runSweep(input string name, input bit sel, input int hold, input bit midStart,
                          input logic [9:0] expRes);
    applyStimulus(sel, 1'b1);
    @(posedge clk); #1;
    applyStimulus(sel, 1'b0);
    checkOutput({name, " cleared"}, 32'(getResult(sel)), 32'd0);
    for (int k = 1; k <= 4 * hold; k++) begin
      checkOutput($sformatf("%s status k=%0d", name, k), 32'(getStatus(sel)),
                  32'({1'b1, 1'b0, 2'((k - 1) / hold)}));
      applyStimulus(sel, (midStart && k == 7) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    applyStimulus(sel, 1'b0);
    checkOutput({name, " done status"}, 32'(getStatus(sel)), 32'(4'b0100));
    checkOutput({name, " result"}, 32'(getResult(sel)), 32'(expRes));
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, " held status"}, 32'(getStatus(sel)), 32'(4'b0100));
    checkOutput({name, " held result"}, 32'(getResult(sel)), 32'(expRes));
  endtask

  initial begin
    rst    = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    setFaults(6'd0, 6'd0, 6'd0, 6'd0);
    #2;
    checkOutput("reset statusA", 32'(getStatus(0)), 32'd0);
    checkOutput("reset resultA", 32'(getResult(0)), 32'd0);
    checkOutput("reset statusB", 32'(getStatus(1)), 32'd0);
    checkOutput("reset resultB", 32'(getResult(1)), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    runSweep("cleanA", 0, 5, 0, {1'b1, 3'd0, 4'b0000, 2'd0});

    setFaults(6'd0, 6'd0, 6'b000100, 6'd0);
    runSweep("vec2o2A", 0, 5, 1, {1'b0, 3'd1, 4'b0100, 2'd2});

    setFaults(6'b000001, 6'b000001, 6'b000001, 6'b000001);
    runSweep("allWrongA", 0, 5, 0, {1'b0, 3'd4, 4'b1111, 2'd0});

    setFaults(6'd0, 6'b010000, 6'd0, 6'b100000);
    runSweep("vec1and3A", 0, 5, 0, {1'b0, 3'd2, 4'b1010, 2'd1});

    // Reset lands between edges while vector 1 is on the bus, after vector 0 already failed.
    setFaults(6'b000001, 6'd0, 6'd0, 6'd0);
    applyStimulus(0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    checkOutput("preRst status", 32'(getStatus(0)), 32'(4'b1001));
    checkOutput("preRst result", 32'(getResult(0)), 32'(10'b0_001_0001_00));
    #3;
    rst = 1'b1;
    applyStimulus(0, 1'b1);
    #1;
    checkOutput("asyncRst status", 32'(getStatus(0)), 32'd0);
    checkOutput("asyncRst result", 32'(getResult(0)), 32'd0);
    @(posedge clk); #1;
    checkOutput("rstStart status", 32'(getStatus(0)), 32'd0);
    rst = 1'b0;
    applyStimulus(0, 1'b0);
    @(posedge clk); #1;
    checkOutput("postRst status", 32'(getStatus(0)), 32'd0);
    setFaults(6'd0, 6'd0, 6'd0, 6'd0);
    runSweep("afterRstA", 0, 5, 0, {1'b1, 3'd0, 4'b0000, 2'd0});

    runSweep("cleanB", 1, 2, 0, {1'b1, 3'd0, 4'b0000, 2'd0});
    setFaults(6'd0, 6'd0, 6'd0, 6'b000010);
    runSweep("vec3B", 1, 2, 0, {1'b0, 3'd1, 4'b1000, 2'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
